// File: rtl/fetch_unit.sv
// Instruction fetch and branch/halt sequencing for a 16-bit core.
// Alternates a memory-handshake fetch cycle with a single execute cycle that resolves the next PC.
module fetch_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_ack_i,
    output logic [15:0] inst_o,
    output logic        inst_valid_o,
    input  logic [3:0]  bs_i,
    input  logic [5:0]  off_i,
    input  logic        halt_i,
    input  logic        z_i,
    input  logic        n_i,
    output logic [15:0] pc_o,
    output logic        halted_o
);

    // One-hot so each status output is a flop bit, free of decode glitches.
    typedef enum logic [2:0] {
        StFetch  = 3'b001,
        StExec   = 3'b010,
        StHalted = 3'b100
    } state_e;

    localparam logic [3:0] BsBeq  = 4'b0000;
    localparam logic [3:0] BsBne  = 4'b0001;
    localparam logic [3:0] BsBgez = 4'b0010;
    localparam logic [3:0] BsBltz = 4'b0011;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] inst_q;
    logic        taken;
    logic [15:0] off_bytes;

    always_comb begin
        taken = 1'b0;
        case (bs_i)
            BsBeq:   taken = z_i;
            BsBne:   taken = ~z_i;
            BsBgez:  taken = ~n_i;
            BsBltz:  taken = n_i;
            default: taken = 1'b0;
        endcase
    end

    // Offset is in instruction words; convert to a sign-extended byte offset.
    assign off_bytes = {{9{off_i[5]}}, off_i, 1'b0};

    always_comb begin
        pc_d = pc_q + 16'd2;
        if (taken) begin
            pc_d = pc_q + 16'd2 + off_bytes;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            pc_q    <= 16'h0000;
            inst_q  <= 16'h0000;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack_i) begin
                        inst_q  <= imem_rdata_i;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (halt_i) begin
                        state_q <= StHalted;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= StFetch;
                    end
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StFetch;
            endcase
        end
    end

    assign imem_req_o   = state_q[0];
    assign inst_valid_o = state_q[1];
    assign halted_o     = state_q[2];
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a driver issues fetch/execute transactions and queues the
// expected execute-cycle view; a negedge monitor pops and compares whenever INST_VALID is seen.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic [3:0]  bs;
    logic [5:0]  off;
    logic        halt;
    logic        z;
    logic        n;
    logic [15:0] pc_o;
    logic        halted_o;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_pc;
    logic [15:0] prev_inst;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata),
        .imem_ack_i   (imem_ack),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .bs_i         (bs),
        .off_i        (off),
        .halt_i       (halt),
        .z_i          (z),
        .n_i          (n),
        .pc_o         (pc_o),
        .halted_o     (halted_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference next-PC rule, straight from the branch table in plain arithmetic.
    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [3:0] b,
                                               input logic [5:0] o, input logic h,
                                               input logic zz, input logic nn);
        int  s;
        bit  t;
        if (h) return pc;
        s = o[5] ? int'(o) - 64 : int'(o);
        case (b)
            4'd0:    t = zz;
            4'd1:    t = !zz;
            4'd2:    t = !nn;
            4'd3:    t = nn;
            default: t = 1'b0;
        endcase
        return 16'(int'(pc) + 2 + (t ? 2 * s : 0));
    endfunction

    // Monitor: every execute cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (inst_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL exec_unexpected: INST_VALID=1 with no instruction delivered");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("exec_pc", {16'h0, pc_o}, {16'h0, e.pc});
                chk("exec_inst", {16'h0, inst_o}, {16'h0, e.inst});
                chk("exec_req", {31'h0, imem_req_o}, 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        imem_ack   = 1'($urandom % 2);
        imem_rdata = 16'($urandom);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        imem_ack  = 1'b0;
        m_pc      = 16'h0000;
        prev_inst = 16'h0000;
        chk("rst_inst", {16'h0, inst_o}, 32'h0);
        chk("rst_pc", {16'h0, pc_o}, 32'h0);
        chk("rst_addr", {16'h0, imem_addr_o}, 32'h0);
        chk("rst_req", {31'h0, imem_req_o}, 32'h1);
        chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("rst_halted", {31'h0, halted_o}, 32'h0);
    endtask

    task automatic fetch_checks();
        chk("fetch_req", {31'h0, imem_req_o}, 32'h1);
        chk("fetch_addr", {16'h0, imem_addr_o}, {16'h0, m_pc});
        chk("fetch_valid", {31'h0, inst_valid_o}, 32'h0);
        chk("fetch_inst_hold", {16'h0, inst_o}, {16'h0, prev_inst});
    endtask

    // One instruction: d wait cycles, ack cycle, then the execute cycle. Starts and ends 1ns
    // after a rising edge.
    task automatic step(input int d, input logic [15:0] r, input logic spur,
                        input logic [3:0] b, input logic [5:0] o, input logic h,
                        input logic zz, input logic nn);
        exp_t e;
        for (int i = 0; i < d; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            fetch_checks();
            @(posedge clk);
            #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = r;
        fetch_checks();
        @(posedge clk);
        #1;
        imem_ack   = spur;
        imem_rdata = 16'($urandom);
        bs         = b;
        off        = o;
        halt       = h;
        z          = zz;
        n          = nn;
        e.pc       = m_pc;
        e.inst     = r;
        sb_q.push_back(e);
        m_pc       = model_next(m_pc, b, o, h, zz, nn);
        prev_inst  = r;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        halt     = 1'b0;
        bs       = 4'($urandom);
        off      = 6'($urandom);
    endtask

    task automatic halted_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack   = 1'($urandom % 2);
            imem_rdata = 16'($urandom);
            bs         = 4'($urandom);
            halt       = 1'($urandom % 2);
            chk("halt_flag", {31'h0, halted_o}, 32'h1);
            chk("halt_req", {31'h0, imem_req_o}, 32'h0);
            chk("halt_valid", {31'h0, inst_valid_o}, 32'h0);
            chk("halt_pc", {16'h0, pc_o}, {16'h0, m_pc});
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        halt     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        bs = 4'd4; off = '0; halt = 1'b0; z = 1'b0; n = 1'b0;
        m_pc = '0; prev_inst = '0;
        @(posedge clk);
        do_reset();

        // Sequential flow with zero-wait memory.
        step(0, 16'hF000, 1'b0, 4'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("seq_addr", {16'h0, imem_addr_o}, 32'h0002);
        // Taken BEQ to 0x10, then BEQ taken / not taken from 0x10.
        step(1, 16'h1111, 1'b1, 4'd0, 6'd6, 1'b0, 1'b1, 1'b0);
        chk("beq_to_10", {16'h0, pc_o}, 32'h0010);
        step(5, 16'h2222, 1'b1, 4'd0, 6'b000011, 1'b0, 1'b1, 1'b0);
        chk("beq_taken", {16'h0, pc_o}, 32'h0018);
        do_reset();
        step(0, 16'h3333, 1'b0, 4'd0, 6'd7, 1'b0, 1'b1, 1'b0);
        step(2, 16'h4444, 1'b0, 4'd0, 6'b000011, 1'b0, 1'b0, 1'b0);
        chk("beq_not_taken", {16'h0, pc_o}, 32'h0012);
        // Backward branch wrapping below zero and back.
        do_reset();
        step(0, 16'h5555, 1'b0, 4'd3, 6'b111110, 1'b0, 1'b0, 1'b1);
        chk("bltz_wrap", {16'h0, pc_o}, 32'hFFFE);
        step(0, 16'h6666, 1'b0, 4'd4, 6'b111110, 1'b0, 1'b0, 1'b1);
        chk("wrap_fwd", {16'h0, pc_o}, 32'h0000);
        // Halt beats a taken branch at 0x20.
        step(0, 16'h7777, 1'b0, 4'd0, 6'd15, 1'b0, 1'b1, 1'b0);
        step(0, 16'h8888, 1'b0, 4'd0, 6'd5, 1'b1, 1'b1, 1'b0);
        chk("halt_pc_20", {16'h0, pc_o}, 32'h0020);
        halted_phase(22);
        do_reset();
        // Reset colliding with an ack at 0x40.
        step(0, 16'h9999, 1'b0, 4'd0, 6'd31, 1'b0, 1'b1, 1'b0);
        chk("at_40", {16'h0, imem_addr_o}, 32'h0040);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hABCD;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        imem_ack = 1'b0;
        m_pc      = 16'h0000;
        prev_inst = 16'h0000;
        chk("midfetch_inst", {16'h0, inst_o}, 32'h0);
        chk("midfetch_pc", {16'h0, pc_o}, 32'h0);
        chk("midfetch_valid", {31'h0, inst_valid_o}, 32'h0);

        for (int k = 0; k < 300; k++) begin
            logic h;
            h = ($urandom % 20) == 0;
            step(int'($urandom_range(0, 5)), 16'($urandom), 1'($urandom % 2),
                 4'($urandom_range(0, 5)), 6'($urandom), h, 1'($urandom % 2),
                 1'($urandom % 2));
            if (h) begin
                halted_phase(int'($urandom_range(1, 25)));
                do_reset();
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
